// File: rtl/ring_pkg.sv
// Shared ring definitions: control-word width, flit-valid bit position and word type.
package ring_pkg;

    localparam int unsigned CONTROL_W         = 144;
    localparam int unsigned CONTROL_VALID_BIT = 143;

    typedef logic [CONTROL_W-1:0] control_w_t;

endpackage : ring_pkg

// File: rtl/cb_stage.sv
// One boundary register with async active-low clear.
// Define CLOCK_BOUNDARY_VALID_GATE_EN to load only words whose valid bit is set (idle words load as 0).
module cb_stage
    import ring_pkg::*;
#(
    parameter int unsigned WIDTH     = CONTROL_W,
    parameter int unsigned VALID_BIT = CONTROL_VALID_BIT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] d_next;

    if (VALID_BIT >= WIDTH) begin : g_bad_valid_bit
        $error("cb_stage: VALID_BIT must lie inside the control word");
    end

`ifdef CLOCK_BOUNDARY_VALID_GATE_EN
    always_comb begin
        d_next = '0;
        if (d[VALID_BIT]) begin
            d_next = d;
        end
    end
`else
    always_comb begin
        d_next = d;
    end
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= '0;
        end else begin
            q <= d_next;
        end
    end

endmodule : cb_stage

// File: rtl/clock_boundary.sv
// Registered boundary for one ring port's control word: output is the input delayed by STAGES clocks.
// STAGES=0 is a combinational passthrough; CLOCK_BOUNDARY_VALID_GATE_EN enables per-stage valid gating.
module clock_boundary
    import ring_pkg::*;
#(
    parameter int unsigned WIDTH     = CONTROL_W,
    parameter int unsigned STAGES    = 1,
    parameter int unsigned VALID_BIT = CONTROL_VALID_BIT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] port0_ci,
    output logic [WIDTH-1:0] port0_co
);

    if (STAGES > 4) begin : g_bad_stages
        $error("clock_boundary: STAGES must be in 0..4");
    end

    if (STAGES == 0) begin : g_bypass
        assign port0_co = port0_ci;
    end else begin : g_pipe
        // chain[0] is the port input, chain[i+1] is the output of stage i
        logic [WIDTH-1:0] chain [STAGES+1];

        assign chain[0] = port0_ci;

        for (genvar i = 0; i < STAGES; i++) begin : g_stage
            cb_stage #(
                .WIDTH    (WIDTH),
                .VALID_BIT(VALID_BIT)
            ) u_stage (
                .clk(clk),
                .rst(rst),
                .d  (chain[i]),
                .q  (chain[i+1])
            );
        end

        assign port0_co = chain[STAGES];
    end

endmodule : clock_boundary

// File: tb/tb_clock_boundary.sv
// Directed bench for clock_boundary: STAGES=0, 1 and 2 instances share clock, reset and input.
module tb_clock_boundary;
    import ring_pkg::*;

    logic       clk;
    logic       rst;
    control_w_t ci;
    control_w_t co0, co1, co2;

    int unsigned tests_run;
    int unsigned tests_failed;

    control_w_t pat;
    control_w_t hot;
    control_w_t pat_v;

    clock_boundary #(.WIDTH(CONTROL_W), .STAGES(0), .VALID_BIT(CONTROL_VALID_BIT)) u_s0 (
        .clk(clk), .rst(rst), .port0_ci(ci), .port0_co(co0));
    clock_boundary #(.WIDTH(CONTROL_W), .STAGES(1), .VALID_BIT(CONTROL_VALID_BIT)) u_s1 (
        .clk(clk), .rst(rst), .port0_ci(ci), .port0_co(co1));
    clock_boundary #(.WIDTH(CONTROL_W), .STAGES(2), .VALID_BIT(CONTROL_VALID_BIT)) u_s2 (
        .clk(clk), .rst(rst), .port0_ci(ci), .port0_co(co2));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Value a stage captures from word w.
    function automatic control_w_t g(input control_w_t w);
`ifdef CLOCK_BOUNDARY_VALID_GATE_EN
        return w[CONTROL_VALID_BIT] ? w : '0;
`else
        return w;
`endif
    endfunction

    task automatic check(input string tag, input control_w_t obs, input control_w_t exp);
        tests_run++;
        assert (obs === exp) else begin
            tests_failed++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        pat   = 144'h0123456789abcdef0123456789abcdef;
        hot   = (144'd1 << 143) | 144'hff;
        pat_v = pat | (144'd1 << 143);

        // reset hold
        rst = 1'b0;
        ci  = pat;
        repeat (3) step();
        check("reset_s1", co1, '0);
        check("reset_s2", co2, '0);
        check("reset_s0_pass", co0, pat);

        // basic latency
        @(negedge clk);
        rst = 1'b1;
        ci  = '0;
        step();
        check("lat_zero_s1", co1, '0);
        @(negedge clk);
        ci = pat;
        step();
        check("lat_pat_s1", co1, g(pat));
        check("lat_pat_s2_not_yet", co2, '0);

        // back-to-back streaming
        @(negedge clk); ci = 144'd1; step();
        check("stream_a_s1", co1, g(144'd1));
        check("stream_a_s2", co2, g(pat));
        @(negedge clk); ci = 144'd2; step();
        check("stream_b_s1", co1, g(144'd2));
        check("stream_b_s2", co2, g(144'd1));
        @(negedge clk); ci = 144'd3; step();
        check("stream_c_s2", co2, g(144'd2));
        @(negedge clk); ci = hot; step();
        check("stream_d_s2", co2, g(144'd3));
        check("stream_d_s1", co1, hot);
        @(negedge clk); step();
        check("hot_s2", co2, hot);

        // async reset mid-stream, sampled between edges
        @(negedge clk);
        #1;
        rst = 1'b0;
        #1;
        check("async_rst_s1", co1, '0);
        check("async_rst_s2", co2, '0);
        step();
        check("rst_held_s2", co2, '0);

        // release: output stays 0 until the new word has crossed every stage
        @(negedge clk);
        rst = 1'b1;
        ci  = hot;
        step();
        check("release_s1", co1, hot);
        check("release_s2_empty", co2, '0);
        step();
        check("release_s2", co2, hot);

        // combinational passthrough, no clock edge in between
        @(negedge clk);
        ci = 144'ha5;
        #1;
        check("pass_a5", co0, 144'ha5);
        check("pass_s1_unchanged", co1, hot);

        // valid gating boundary
        @(negedge clk); ci = pat; step();
        check("gate_invalid_s1", co1, g(pat));
        @(negedge clk); ci = pat_v; step();
        check("gate_valid_s1", co1, pat_v);
        check("gate_valid_s2", co2, g(pat));

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule : tb_clock_boundary
